// File: rtl/id_exe_stage_reg_if.sv
// ----------------------------------------------------------------------------
// id_exe_stage_reg_if
//   Bundles the decode-side inputs and the EXE-side registered outputs of the
//   ID/EXE pipeline register.
//
//   Handshake semantics: there is no valid/ready pair on this boundary.
//   Decode presents a complete instruction (or a stall/flush request) every
//   cycle and the stage always accepts it on the rising edge; e_valid marks
//   whether the EXE slot holds a real instruction (1) or a bubble (0).
//   Nothing can back-pressure decode from here, so no ready signal exists.
//
//   Modports:
//     slave  - used by id_exe_stage_reg (decode fields in, e_* out)
//     master - used by whoever drives decode fields and observes e_*
//   dbg_state exposes the action taken at the most recent edge
//   (0 = load, 1 = stall bubble, 2 = flush bubble).
// ----------------------------------------------------------------------------
interface id_exe_stage_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
);
  // decode side
  logic               wreg;
  logic               m2reg;
  logic               wmem;
  logic [2:0]         aluc;
  logic [RADDR_W-1:0] rd;
  logic [DATA_W-1:0]  qa;
  logic [DATA_W-1:0]  qb;
  logic [DATA_W-1:0]  imm;
  logic [4:0]         sa;
  logic [1:0]         ADEPEN;
  logic [1:0]         BDEPEN;
  logic [1:0]         STOREDEPEN;
  logic [DATA_W-1:0]  alu_exe;
  logic [DATA_W-1:0]  mem_data;
  logic               LOADDEPEN;
  logic               CancelInst;
  // EXE side
  logic               e_valid;
  logic               e_wreg;
  logic               e_m2reg;
  logic               e_wmem;
  logic [2:0]         e_aluc;
  logic [RADDR_W-1:0] e_rd;
  logic [DATA_W-1:0]  e_a;
  logic [DATA_W-1:0]  e_b;
  logic [DATA_W-1:0]  e_sdata;
  logic [1:0]         dbg_state;

  modport slave (
    input  wreg, m2reg, wmem, aluc, rd, qa, qb, imm, sa,
           ADEPEN, BDEPEN, STOREDEPEN, alu_exe, mem_data,
           LOADDEPEN, CancelInst,
    output e_valid, e_wreg, e_m2reg, e_wmem, e_aluc, e_rd,
           e_a, e_b, e_sdata, dbg_state
  );

  modport master (
    output wreg, m2reg, wmem, aluc, rd, qa, qb, imm, sa,
           ADEPEN, BDEPEN, STOREDEPEN, alu_exe, mem_data,
           LOADDEPEN, CancelInst,
    input  e_valid, e_wreg, e_m2reg, e_wmem, e_aluc, e_rd,
           e_a, e_b, e_sdata, dbg_state
  );
endinterface

// File: rtl/id_exe_stage_reg.sv
// ----------------------------------------------------------------------------
// id_exe_stage_reg
//   ID/EXE pipeline register with operand selection for the 5-stage MIPS
//   core. Each cycle it picks operand A, operand B and store data from the
//   register file, immediate, shift amount or forwarded EXE/MEM results and
//   registers them together with the control bits into the EXE stage, or
//   inserts an all-zero bubble on a stall (LOADDEPEN) or flush (CancelInst).
//
//   Ports:
//     Clock       in   rising-edge clock
//     Resetn      in   asynchronous active-low reset, clears every output
//     bus         slave modport of id_exe_stage_reg_if (decode in, e_* out)
//     bubble_cnt  out  16-bit saturating bubble counter, only present when
//                      ID_EXE_BUBBLE_CNT_EN is defined
//
//   Optional feature macro: ID_EXE_BUBBLE_CNT_EN
// ----------------------------------------------------------------------------
module id_exe_stage_reg #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  id_exe_stage_reg_if.slave      bus
`ifdef ID_EXE_BUBBLE_CNT_EN
  ,
  output logic [15:0]            bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_LOAD         = 2'd0,
    ST_BUBBLE_STALL = 2'd1,
    ST_BUBBLE_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               w_load;

  logic [DATA_W-1:0]  w_a;
  logic [DATA_W-1:0]  w_b;
  logic [DATA_W-1:0]  w_sdata;
  logic [DATA_W-1:0]  w_sa_ext;

  logic               r_valid;
  logic               r_wreg;
  logic               r_m2reg;
  logic               r_wmem;
  logic [2:0]         r_aluc;
  logic [RADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic [DATA_W-1:0]  r_sdata;

  assign w_sa_ext = {{(DATA_W-5){1'b0}}, bus.sa};

  // Operand selection. Store-data code 1 is reserved and aliases qb.
  always_comb begin
    w_a     = bus.qa;
    w_b     = bus.qb;
    w_sdata = bus.qb;
    case (bus.ADEPEN)
      2'd0:    w_a = bus.qa;
      2'd1:    w_a = w_sa_ext;
      2'd2:    w_a = bus.alu_exe;
      default: w_a = bus.mem_data;
    endcase
    case (bus.BDEPEN)
      2'd0:    w_b = bus.qb;
      2'd1:    w_b = bus.imm;
      2'd2:    w_b = bus.alu_exe;
      default: w_b = bus.mem_data;
    endcase
    case (bus.STOREDEPEN)
      2'd2:    w_sdata = bus.alu_exe;
      2'd3:    w_sdata = bus.mem_data;
      default: w_sdata = bus.qb;
    endcase
  end

  // The state names the action taken at an edge. Flush outranks stall so a
  // cancelled instruction can never be resurrected by a pending load stall.
  always_comb begin
    w_next_state = ST_LOAD;
    if (bus.CancelInst)
      w_next_state = ST_BUBBLE_FLUSH;
    else if (bus.LOADDEPEN)
      w_next_state = ST_BUBBLE_STALL;
    w_load = (w_next_state == ST_LOAD);
  end

  // Reset leaves the slot empty, which is indistinguishable from a flush.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      r_state <= ST_BUBBLE_FLUSH;
    else
      r_state <= w_next_state;
  end

  // A bubble is all zeros: no register/memory write and no stale data.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_aluc  <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sdata <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_wreg  <= bus.wreg;
      r_m2reg <= bus.m2reg;
      r_wmem  <= bus.wmem;
      r_aluc  <= bus.aluc;
      r_rd    <= bus.rd;
      r_a     <= w_a;
      r_b     <= w_b;
      r_sdata <= w_sdata;
    end else begin
      r_valid <= 1'b0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_wmem  <= 1'b0;
      r_aluc  <= '0;
      r_rd    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sdata <= '0;
    end
  end

  assign bus.e_valid   = r_valid;
  assign bus.e_wreg    = r_wreg;
  assign bus.e_m2reg   = r_m2reg;
  assign bus.e_wmem    = r_wmem;
  assign bus.e_aluc    = r_aluc;
  assign bus.e_rd      = r_rd;
  assign bus.e_a       = r_a;
  assign bus.e_b       = r_b;
  assign bus.e_sdata   = r_sdata;
  assign bus.dbg_state = r_state;

`ifdef ID_EXE_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn)
      r_bubble_cnt <= '0;
    else if (!w_load && (r_bubble_cnt != 16'hFFFF))
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;
  localparam int DATA_W  = 32;
  localparam int RADDR_W = 5;
  // {valid, wreg, m2reg, wmem, aluc, rd, a, b, sdata, bubble_cnt}
  localparam int EXP_W   = 4 + 3 + RADDR_W + 3*DATA_W + 16;

  // ---------------- clock / reset ----------------
  logic Clock;
  logic Resetn;
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  id_exe_stage_reg_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) bus ();

  logic [15:0] act_cnt;
`ifdef ID_EXE_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
  assign act_cnt = bubble_cnt;
`else
  assign act_cnt = 16'd0;
`endif

  id_exe_stage_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
`ifdef ID_EXE_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int               n_checks;
  int               n_errors;
  int               model_cnt;

  function automatic logic [EXP_W-1:0] actual_vec();
    return {bus.e_valid, bus.e_wreg, bus.e_m2reg, bus.e_wmem, bus.e_aluc,
            bus.e_rd, bus.e_a, bus.e_b, bus.e_sdata, act_cnt};
  endfunction

  function automatic logic [15:0] cnt_field(input int c);
`ifdef ID_EXE_BUBBLE_CNT_EN
    return 16'(c);
`else
    return 16'd0;
`endif
  endfunction

  // Reference model: what the EXE slot should hold after the coming edge,
  // written from the selection tables rather than from any RTL structure.
  task automatic push_expected();
    logic [DATA_W-1:0] a_src [4];
    logic [DATA_W-1:0] b_src [4];
    logic [DATA_W-1:0] s_src [4];
    logic [EXP_W-1:0]  e;
    if (bus.CancelInst || bus.LOADDEPEN) begin
      if (model_cnt < 65535) model_cnt++;
      e = '0;
      e[15:0] = cnt_field(model_cnt);
    end else begin
      a_src = '{bus.qa, DATA_W'(bus.sa), bus.alu_exe, bus.mem_data};
      b_src = '{bus.qb, bus.imm, bus.alu_exe, bus.mem_data};
      s_src = '{bus.qb, bus.qb, bus.alu_exe, bus.mem_data};
      e = {1'b1, bus.wreg, bus.m2reg, bus.wmem, bus.aluc, bus.rd,
           a_src[bus.ADEPEN], b_src[bus.BDEPEN], s_src[bus.STOREDEPEN],
           cnt_field(model_cnt)};
    end
    exp_q.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [EXP_W-1:0] exp);
    logic [EXP_W-1:0] act;
    act = actual_vec();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge Clock) begin
    #1;
    if (exp_q.size() > 0) check_now("exe_slot", exp_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.wreg = 0; bus.m2reg = 0; bus.wmem = 0; bus.aluc = 0; bus.rd = 0;
    bus.qa = 0; bus.qb = 0; bus.imm = 0; bus.sa = 0;
    bus.ADEPEN = 0; bus.BDEPEN = 0; bus.STOREDEPEN = 0;
    bus.alu_exe = 0; bus.mem_data = 0; bus.LOADDEPEN = 0; bus.CancelInst = 0;
  endtask

  // Waits for the half-cycle point where inputs may change for the next edge.
  task automatic next_slot();
    @(negedge Clock);
  endtask

  task automatic random_slot(input int stall_pct, input int flush_pct);
    next_slot();
    bus.wreg       = 1'($urandom_range(0, 1));
    bus.m2reg      = 1'($urandom_range(0, 1));
    bus.wmem       = 1'($urandom_range(0, 1));
    bus.aluc       = 3'($urandom_range(0, 7));
    bus.rd         = 5'($urandom_range(0, 31));
    bus.qa         = $urandom;
    bus.qb         = $urandom;
    bus.imm        = $urandom;
    bus.sa         = 5'($urandom_range(0, 31));
    bus.ADEPEN     = 2'($urandom_range(0, 3));
    bus.BDEPEN     = 2'($urandom_range(0, 3));
    bus.STOREDEPEN = 2'($urandom_range(0, 3));
    bus.alu_exe    = $urandom;
    bus.mem_data   = $urandom;
    bus.LOADDEPEN  = ($urandom_range(0, 99) < stall_pct);
    bus.CancelInst = ($urandom_range(0, 99) < flush_pct);
    push_expected();
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge Clock);
      budget--;
    end
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks  = 0;
    n_errors  = 0;
    model_cnt = 0;
    clear_inputs();
    Resetn = 1'b0;

    // Reset holds everything at zero even with live decode inputs.
    bus.wreg = 1; bus.qa = 32'h1234;
    repeat (3) @(posedge Clock);
    #2 check_now("reset_hold", '0);

    // First capture after reset release.
    next_slot();
    Resetn = 1'b1;
    push_expected();                     // e_a=1234, e_wreg=1, e_valid=1

    // Forwarding selects for A.
    next_slot(); clear_inputs();
    bus.qa = 5; bus.alu_exe = 32'hAA; bus.mem_data = 32'hBB; bus.ADEPEN = 2;
    push_expected();
    next_slot(); bus.ADEPEN = 3; push_expected();
    next_slot(); bus.ADEPEN = 1; bus.sa = 7; push_expected();

    // B immediate and store data from MEM.
    next_slot(); clear_inputs();
    bus.BDEPEN = 1; bus.imm = 32'hFFFF_FFFC; push_expected();
    next_slot(); clear_inputs();
    bus.wmem = 1; bus.STOREDEPEN = 3; bus.mem_data = 32'h55; bus.qb = 32'h77;
    push_expected();
    next_slot(); bus.STOREDEPEN = 1; push_expected();  // reserved code -> qb

    // Two stall bubbles, then the re-presented instruction goes through.
    next_slot(); clear_inputs();
    bus.wreg = 1; bus.m2reg = 1; bus.rd = 9; bus.LOADDEPEN = 1;
    push_expected();
    next_slot(); push_expected();
    next_slot(); bus.LOADDEPEN = 0; push_expected();

    // Flush outranks stall.
    next_slot(); clear_inputs();
    bus.wmem = 1; bus.CancelInst = 1; bus.LOADDEPEN = 1; bus.rd = 3;
    push_expected();
    next_slot(); bus.CancelInst = 0; bus.LOADDEPEN = 0; push_expected();
    drain();

    // Asynchronous reset between edges while the slot is valid.
    @(posedge Clock);
    #3 Resetn = 1'b0;
    #1 model_cnt = 0;
    check_now("async_reset", '0);
    next_slot(); Resetn = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 400; i++) random_slot(20, 15);
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
